// File: rtl/debug_unit.sv
// Host-side debug controller for the MIPS pipeline: decodes UART commands, loads
// instruction memory, runs or steps the core, and streams register/memory dumps back.
module debug_unit #(
  parameter int NB_REG   = 32,
  parameter int NB_WIDHT = 9,
  parameter int NB_BYTE  = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  output logic [NB_BYTE-1:0]  o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_dunit_clk_en,
  output logic                o_dunit_reset_pc,
  output logic                o_dunit_w_mem,
  output logic [NB_WIDHT-1:0] o_dunit_addr,
  output logic [NB_REG-1:0]   o_dunit_data_if,
  input  logic [NB_REG-1:0]   i_dunit_reg,
  input  logic [NB_REG-1:0]   i_dunit_mem_data,
  input  logic                i_halt
);

  localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
  localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h43;
  localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;
  localparam logic [NB_BYTE-1:0] ACK_BYTE = 8'h06;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ACK, S_RUN, S_STEP, S_DADDR, S_DCAP, S_DSEND
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [5:0]          k_q, k_d, k_next_s;
  logic                last_q, last_d;
  logic [NB_REG-1:0]   word_q, word_d, new_word_s, src_s;
  logic                clk_en_q, clk_en_d;
  logic                reset_pc_q, reset_pc_d;
  logic                w_mem_q, w_mem_d;
  logic [NB_WIDHT-1:0] addr_q, addr_d, next_addr_s;
  logic [NB_REG-1:0]   data_if_q, data_if_d;
  logic [NB_BYTE-1:0]  tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;

  assign new_word_s  = {word_q[NB_REG-NB_BYTE-1:0], i_rx_data};
  assign src_s       = k_q[5] ? i_dunit_mem_data : i_dunit_reg;
  assign k_next_s    = k_q + 6'd1;
  // Words 0..31 index registers; words 32..63 walk data memory one word at a time.
  assign next_addr_s = k_next_s[5] ? NB_WIDHT'({k_next_s[4:0], 2'b00})
                                   : NB_WIDHT'(k_next_s[4:0]);

  // Next-state and next-output computation for the command/load/dump FSM.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    k_d        = k_q;
    last_d     = last_q;
    word_d     = word_q;
    clk_en_d   = 1'b0;
    reset_pc_d = reset_pc_q;
    w_mem_d    = 1'b0;
    addr_d     = addr_q;
    data_if_d  = data_if_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      S_IDLE: begin
        reset_pc_d = 1'b0;
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d    = S_LOAD;
              reset_pc_d = 1'b1;
              addr_d     = '0;
              bcnt_d     = 2'd0;
              last_d     = 1'b0;
            end
            CMD_RUN: begin
              state_d  = S_RUN;
              clk_en_d = 1'b1;
            end
            CMD_STEP: begin
              state_d  = S_STEP;
              clk_en_d = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        reset_pc_d = 1'b1;
        // Address advances the cycle after the write strobe so addr/data stay stable with it.
        if (w_mem_q) begin
          addr_d = addr_q + NB_WIDHT'(4);
          if (last_q) begin
            state_d    = S_ACK;
            reset_pc_d = 1'b0;
            tx_data_d  = ACK_BYTE;
            tx_valid_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          addr_d = addr_q;
        end
        if (i_rx_valid && !last_q) begin
          word_d = new_word_s;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            data_if_d = new_word_s;
            w_mem_d   = 1'b1;
            last_d    = (new_word_s == {NB_REG{1'b1}});
          end else begin
            w_mem_d = 1'b0;
          end
        end else begin
          word_d = word_q;
        end
      end
      S_ACK: begin
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      S_RUN: begin
        if (i_halt) begin
          state_d = S_DADDR;
          addr_d  = '0;
          k_d     = 6'd0;
        end else begin
          clk_en_d = 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_DADDR;
        addr_d  = '0;
        k_d     = 6'd0;
      end
      S_DADDR: state_d = S_DCAP;
      S_DCAP: begin
        word_d     = src_s;
        tx_data_d  = src_s[NB_REG-1 -: NB_BYTE];
        tx_valid_d = 1'b1;
        bcnt_d     = 2'd0;
        state_d    = S_DSEND;
      end
      S_DSEND: begin
        if (i_tx_ready) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            tx_valid_d = 1'b0;
            if (k_q == 6'd63) begin
              state_d = S_IDLE;
              addr_d  = '0;
            end else begin
              k_d     = k_next_s;
              addr_d  = next_addr_s;
              state_d = S_DADDR;
            end
          end else begin
            word_d    = word_q << NB_BYTE;
            tx_data_d = word_q[NB_REG-NB_BYTE-1 -: NB_BYTE];
          end
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        reset_pc_d = 1'b0;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      bcnt_q     <= 2'd0;
      k_q        <= 6'd0;
      last_q     <= 1'b0;
      word_q     <= '0;
      clk_en_q   <= 1'b0;
      reset_pc_q <= 1'b0;
      w_mem_q    <= 1'b0;
      addr_q     <= '0;
      data_if_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      k_q        <= k_d;
      last_q     <= last_d;
      word_q     <= word_d;
      clk_en_q   <= clk_en_d;
      reset_pc_q <= reset_pc_d;
      w_mem_q    <= w_mem_d;
      addr_q     <= addr_d;
      data_if_q  <= data_if_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign o_tx_data        = tx_data_q;
  assign o_tx_valid       = tx_valid_q;
  assign o_dunit_clk_en   = clk_en_q;
  assign o_dunit_reset_pc = reset_pc_q;
  assign o_dunit_w_mem    = w_mem_q;
  assign o_dunit_addr     = addr_q;
  assign o_dunit_data_if  = data_if_q;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: scoreboarded tx stream, load write log,
// clock-enable counting, backpressure and reset-mid-load scenarios.
module tb_debug_unit;
  localparam int NB_REG = 32, NB_WIDHT = 9, NB_BYTE = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        clk_en, reset_pc, w_mem;
  logic [8:0]  addr;
  logic [31:0] data_if;
  logic [31:0] dunit_reg = 32'h0;
  logic [31:0] dunit_mem = 32'h0;
  logic        halt = 1'b0;

  int total = 0, bad = 0;
  int tx_cnt = 0, cyc = 0, first_tx_cyc = 0, last_tx_cyc = 0, clk_en_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  dump_b[$];
  logic [8:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic        stall_pending = 1'b0;
  logic [7:0]  stall_data = 8'h00;

  debug_unit #(.NB_REG(NB_REG), .NB_WIDHT(NB_WIDHT), .NB_BYTE(NB_BYTE)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_dunit_clk_en(clk_en), .o_dunit_reset_pc(reset_pc), .o_dunit_w_mem(w_mem),
    .o_dunit_addr(addr), .o_dunit_data_if(data_if),
    .i_dunit_reg(dunit_reg), .i_dunit_mem_data(dunit_mem), .i_halt(halt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] regval(input logic [4:0] r);
    if (r == 5'd3) return 32'h12345678;
    return 32'hC0DE0000 + {27'd0, r} * 32'h00010103;
  endfunction

  function automatic logic [31:0] memval(input logic [8:0] a);
    return 32'h5A000000 ^ ({23'd0, a} * 32'h00030507);
  endfunction

  // Register file / data memory model with one cycle of read latency.
  always @(posedge clk) begin
    dunit_reg <= regval(addr[4:0]);
    dunit_mem <= memval(addr);
  end

  // Monitor: tx scoreboard, hold-while-stalled check, write log, clk_en count.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (clk_en === 1'b1) clk_en_cnt = clk_en_cnt + 1;
    if (w_mem === 1'b1) begin
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(data_if);
    end
    if (stall_pending) begin
      total = total + 1;
      if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
        bad = bad + 1;
        $display("FAIL tx_hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, stall_data);
      end
    end
    stall_pending = (tx_valid === 1'b1) && (tx_ready === 1'b0);
    stall_data    = tx_data;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL tx_unexpected: got byte %h, required no transfer", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          bad = bad + 1;
          $display("FAIL tx_byte[%0d]: got %h, required %h", tx_cnt, tx_data, e);
        end
      end
      if (tx_cnt == 0) first_tx_cyc = cyc;
      last_tx_cyc = cyc;
      tx_cnt = tx_cnt + 1;
      dump_b.push_back(tx_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send_byte(w[31-8*j -: 8]);
  endtask

  task automatic push_dump();
    logic [31:0] w;
    for (int k = 0; k < 64; k++) begin
      w = (k < 32) ? regval(5'(k)) : memval(9'((k - 32) * 4));
      for (int j = 0; j < 4; j++) exp_q.push_back(w[31-8*j -: 8]);
    end
  endtask

  task automatic wait_drain(input int max_cyc, input string what);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL %s_timeout: %0d bytes left, required 0", what, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic check_outputs_zero(input string what);
    total = total + 1;
    if ({tx_data, tx_valid, clk_en, reset_pc, w_mem, addr, data_if} !== '0) begin
      bad = bad + 1;
      $display("FAIL %s: tx=%h/%b clk_en=%b reset_pc=%b w_mem=%b addr=%h data=%h, required all 0",
               what, tx_data, tx_valid, clk_en, reset_pc, w_mem, addr, data_if);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_outputs_zero("reset_outputs");
    tick();
    rst_n = 1'b1;
    tick();
    tx_cnt = 0;
    clk_en_cnt = 0;
    send_byte(8'h58);
    halt = 1'b1;
    repeat (10) tick();
    halt = 1'b0;
    @(negedge clk);
    total = total + 1;
    if (tx_cnt != 0 || clk_en_cnt != 0 || reset_pc !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL idle_ignore: tx=%0d clk_en_cycles=%0d reset_pc=%b, required 0 0 0", tx_cnt, clk_en_cnt, reset_pc);
    end
  endtask

  task automatic test_load();
    logic [31:0] words[3];
    words[0] = 32'h20010001;
    words[1] = 32'hAC010004;
    words[2] = 32'hFFFFFFFF;
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_q.push_back(8'h06);
    send_byte(8'h4C);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) begin
        send_byte(words[i][31-8*j -: 8]);
        @(negedge clk);
        total = total + 1;
        if (reset_pc !== 1'b1 || clk_en !== 1'b0) begin
          bad = bad + 1;
          $display("FAIL load_ctrl: reset_pc=%b clk_en=%b, required 1 0", reset_pc, clk_en);
        end
      end
      total = total + 1;
      if (w_mem !== 1'b1 || addr !== 9'(i * 4) || data_if !== words[i]) begin
        bad = bad + 1;
        $display("FAIL load_write%0d: w_mem=%b addr=%0d data=%h, required 1 %0d %h", i, w_mem, addr, data_if, i * 4, words[i]);
      end
    end
    wait_drain(20, "ack");
    total = total + 1;
    if (wr_addr_q.size() != 3 || reset_pc !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL load_count: writes=%0d reset_pc=%b, required 3 0", wr_addr_q.size(), reset_pc);
    end
  endtask

  task automatic test_step();
    push_dump();
    clk_en_cnt = 0;
    tx_cnt = 0;
    dump_b.delete();
    send_byte(8'h53);
    @(negedge clk);
    total = total + 1;
    if (clk_en !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL step_clk_en: got %b, required 1", clk_en);
    end
    wait_drain(1000, "step_dump");
    total = total + 1;
    if (clk_en_cnt != 1 || tx_cnt != 256) begin
      bad = bad + 1;
      $display("FAIL step_counts: clk_en_cycles=%0d bytes=%0d, required 1 256", clk_en_cnt, tx_cnt);
    end
    total = total + 1;
    if (dump_b.size() < 16 || {dump_b[12], dump_b[13], dump_b[14], dump_b[15]} !== 32'h12345678) begin
      bad = bad + 1;
      $display("FAIL step_reg3: bytes 12..15 wrong, required 12345678");
    end
    total = total + 1;
    if (last_tx_cyc - first_tx_cyc != 381) begin
      bad = bad + 1;
      $display("FAIL dump_rate: span=%0d cycles, required 381", last_tx_cyc - first_tx_cyc);
    end
  endtask

  task automatic test_run();
    push_dump();
    clk_en_cnt = 0;
    tx_cnt = 0;
    send_byte(8'h43);
    repeat (9) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    @(negedge clk);
    total = total + 1;
    if (clk_en !== 1'b0 || addr !== 9'd0) begin
      bad = bad + 1;
      $display("FAIL halt_stop: clk_en=%b addr=%0d, required 0 0", clk_en, addr);
    end
    wait_drain(1000, "run_dump");
    total = total + 1;
    if (clk_en_cnt != 10 || tx_cnt != 256) begin
      bad = bad + 1;
      $display("FAIL run_counts: clk_en_cycles=%0d bytes=%0d, required 10 256", clk_en_cnt, tx_cnt);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    push_dump();
    tx_cnt = 0;
    send_byte(8'h53);
    while (exp_q.size() != 0 && n < 5000) begin
      tick();
      n++;
      tx_ready = ((n % 47) < 5) ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
    tx_ready = 1'b1;
    wait_drain(10, "bp_dump");
    total = total + 1;
    if (tx_cnt != 256) begin
      bad = bad + 1;
      $display("FAIL bp_count: bytes=%0d, required 256", tx_cnt);
    end
  endtask

  task automatic test_wrap();
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_q.push_back(8'h06);
    send_byte(8'h4C);
    for (int i = 0; i < 130; i++) send_word((i == 129) ? 32'hFFFFFFFF : 32'h01000000 + 32'(i));
    wait_drain(20, "wrap_ack");
    total = total + 1;
    if (wr_addr_q.size() != 130) begin
      bad = bad + 1;
      $display("FAIL wrap_count: writes=%0d, required 130", wr_addr_q.size());
    end else if (wr_addr_q[127] !== 9'd508 || wr_addr_q[128] !== 9'd0 || wr_data_q[128] !== 32'h01000080) begin
      bad = bad + 1;
      $display("FAIL wrap_addr: w127@%0d w128@%0d data=%h, required 508 0 01000080", wr_addr_q[127], wr_addr_q[128], wr_data_q[128]);
    end
  endtask

  task automatic test_reset_mid_load();
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h4C);
    send_byte(8'hDE);
    send_byte(8'hAD);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_mid_load");
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(8'h06);
    send_byte(8'h4C);
    send_word(32'h11223344);
    send_word(32'hFFFFFFFF);
    wait_drain(20, "reload_ack");
    total = total + 1;
    if (wr_addr_q.size() != 2) begin
      bad = bad + 1;
      $display("FAIL reload_count: writes=%0d, required 2", wr_addr_q.size());
    end else if (wr_addr_q[0] !== 9'd0 || wr_data_q[0] !== 32'h11223344) begin
      bad = bad + 1;
      $display("FAIL reload_first: addr=%0d data=%h, required 0 11223344", wr_addr_q[0], wr_data_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_step();
    test_run();
    test_backpressure();
    test_wrap();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
